merge_pair_scheduler: RTL and testbench

- Time-shares one 16-wide merger datapath between NUM_PAIRS pairs of sorted input streams.
- Grants one pair at a time, round-robin, and steers the merger's FIFO-1/FIFO-2 input muxes to that pair.
- Holds the grant until both input runs have delivered their zero-key terminator tuple and the merger has emitted its output terminator, then releases.
- Reports the run's output beat count.

---
 rtl/merge_pair_scheduler_if.sv | 49 ++++
 rtl/merge_pair_scheduler.sv | 151 +++++++++++++++
 tb/tb_merge_pair_scheduler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/merge_pair_scheduler_if.sv
// rtl/merge_pair_scheduler_if.sv - handshake bundle between stream pairs, merger and pair scheduler
//
// Purpose: groups the request/terminator/write strobes fed to the scheduler and
// the grant/route/status signals it drives.
// Ports (signals):
//   i_pair_req     per-pair "run ready" request vector
//   i_a_term       terminator dequeued from granted pair's A stream
//   i_b_term       terminator dequeued from granted pair's B stream
//   i_out_write    merger output FIFO write strobe
//   i_out_term     merger output terminator written
//   o_grant_valid  a pair owns the merger
//   o_grant_idx    owning pair index
//   o_grant_onehot one-hot owning pair (zero when no grant)
//   o_route_en     input mux / source read enable
//   o_run_done     one-cycle run completion pulse
//   o_run_beats    output beats of last completed run
//   o_error        sticky protocol / timeout error
// Modports: master drives the i_* strobes, slave is the scheduler.

interface merge_pair_scheduler_if #(
  parameter int NUM_PAIRS  = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int BEAT_WIDTH = 16
);
  logic [NUM_PAIRS-1:0]  i_pair_req;
  logic                  i_a_term;
  logic                  i_b_term;
  logic                  i_out_write;
  logic                  i_out_term;
  logic                  o_grant_valid;
  logic [IDX_WIDTH-1:0]  o_grant_idx;
  logic [NUM_PAIRS-1:0]  o_grant_onehot;
  logic                  o_route_en;
  logic                  o_run_done;
  logic [BEAT_WIDTH-1:0] o_run_beats;
  logic                  o_error;

  modport master (
    output i_pair_req, i_a_term, i_b_term, i_out_write, i_out_term,
    input  o_grant_valid, o_grant_idx, o_grant_onehot, o_route_en,
           o_run_done, o_run_beats, o_error
  );

  modport slave (
    input  i_pair_req, i_a_term, i_b_term, i_out_write, i_out_term,
    output o_grant_valid, o_grant_idx, o_grant_onehot, o_route_en,
           o_run_done, o_run_beats, o_error
  );
endinterface

// File: rtl/merge_pair_scheduler.sv
// rtl/merge_pair_scheduler.sv - round-robin scheduler sharing one merger between stream pairs
//
// Purpose: grants one stream pair at a time to the merger, holds the grant until
// both input runs and the merger output have terminated, counts output beats.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      merge_pair_scheduler_if.slave (requests, terminators, grant, status)

module merge_pair_scheduler #(
  parameter int NUM_PAIRS     = 4,
  parameter int IDX_WIDTH     = 2,
  parameter int BEAT_WIDTH    = 16,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  merge_pair_scheduler_if.slave  bus
);

  localparam int TO_WIDTH = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [IDX_WIDTH-1:0]  grant_idx;
  logic [IDX_WIDTH-1:0]  last_idx;
  logic                  a_done;
  logic                  b_done;
  logic [BEAT_WIDTH-1:0] beat_cnt;
  logic [BEAT_WIDTH-1:0] beat_next;
  logic [BEAT_WIDTH-1:0] run_beats;
  logic [TO_WIDTH-1:0]   timeout_cnt;
  logic                  error;

  logic                  pick_found;
  logic [IDX_WIDTH-1:0]  pick_idx;
  logic                  both_done;
  logic                  timeout_hit;

  // Round-robin pick: first requester strictly above the last grant, else the
  // lowest requester (wrap-around).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int j = 0; j < NUM_PAIRS; j++) begin
      if (!pick_found && bus.i_pair_req[j] && (j > int'(last_idx))) begin
        pick_found = 1'b1;
        pick_idx   = IDX_WIDTH'(j);
      end
    end
    for (int j = 0; j < NUM_PAIRS; j++) begin
      if (!pick_found && bus.i_pair_req[j]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_WIDTH'(j);
      end
    end
  end

  // Terminators seen this cycle count toward leaving RUN immediately.
  assign both_done   = (a_done || bus.i_a_term) && (b_done || bus.i_b_term);
  assign timeout_hit = (timeout_cnt == TO_WIDTH'(DRAIN_TIMEOUT - 1));
  assign beat_next   = (bus.i_out_write && (beat_cnt != {BEAT_WIDTH{1'b1}}))
                       ? beat_cnt + BEAT_WIDTH'(1) : beat_cnt;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (pick_found) state_next = ST_RUN;
      ST_RUN:   if (both_done) state_next = ST_DRAIN;
      ST_DRAIN: if (bus.i_out_term || timeout_hit) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Run bookkeeping: grant index, terminator flags, beat and timeout counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_idx   <= '0;
      last_idx    <= IDX_WIDTH'(NUM_PAIRS - 1);
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      beat_cnt    <= '0;
      run_beats   <= '0;
      timeout_cnt <= '0;
      error       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_idx <= pick_idx;
            beat_cnt  <= '0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
          end
        end
        ST_RUN: begin
          a_done      <= a_done || bus.i_a_term;
          b_done      <= b_done || bus.i_b_term;
          beat_cnt    <= beat_next;
          timeout_cnt <= '0;
          // Output terminator before both inputs finished is a protocol error.
          if (bus.i_out_term) error <= 1'b1;
        end
        ST_DRAIN: begin
          beat_cnt    <= beat_next;
          timeout_cnt <= timeout_cnt + TO_WIDTH'(1);
          // Capture includes a write coincident with the terminator.
          if (state_next == ST_DONE) run_beats <= beat_next;
          if (timeout_hit && !bus.i_out_term) error <= 1'b1;
        end
        ST_DONE: begin
          last_idx <= grant_idx;
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    bus.o_grant_valid  = (state == ST_RUN) || (state == ST_DRAIN);
    bus.o_route_en     = (state == ST_RUN);
    bus.o_run_done     = (state == ST_DONE);
    bus.o_grant_idx    = grant_idx;
    bus.o_run_beats    = run_beats;
    bus.o_error        = error;
    bus.o_grant_onehot = '0;
    for (int j = 0; j < NUM_PAIRS; j++) begin
      bus.o_grant_onehot[j] = bus.o_grant_valid && (grant_idx == IDX_WIDTH'(j));
    end
  end

endmodule

// File: tb/tb_merge_pair_scheduler.sv
// tb/tb_merge_pair_scheduler.sv - self-checking bench for merge_pair_scheduler

module tb_merge_pair_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [15:0] exp_q[$];

  merge_pair_scheduler_if #(.NUM_PAIRS(4), .IDX_WIDTH(2), .BEAT_WIDTH(16)) bus ();

  merge_pair_scheduler #(
    .NUM_PAIRS(4), .IDX_WIDTH(2), .BEAT_WIDTH(16), .DRAIN_TIMEOUT(64)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gv"}, 32'(bus.o_grant_valid), 32'd0);
    chk({tag, "_idx"}, 32'(bus.o_grant_idx), 32'd0);
    chk({tag, "_oh"}, 32'(bus.o_grant_onehot), 32'd0);
    chk({tag, "_route"}, 32'(bus.o_route_en), 32'd0);
    chk({tag, "_done"}, 32'(bus.o_run_done), 32'd0);
    chk({tag, "_beats"}, 32'(bus.o_run_beats), 32'd0);
    chk({tag, "_err"}, 32'(bus.o_error), 32'd0);
  endtask

  task automatic check_grant(input string tag, input int idx);
    chk({tag, "_gv"}, 32'(bus.o_grant_valid), 32'd1);
    chk({tag, "_idx"}, 32'(bus.o_grant_idx), 32'(idx));
    chk({tag, "_oh"}, 32'(bus.o_grant_onehot), 32'(1) << idx);
    chk({tag, "_route"}, 32'(bus.o_route_en), 32'd1);
  endtask

  // Both input terminators in one cycle; moves RUN -> DRAIN.
  task automatic both_terms();
    bus.i_a_term = 1'b1;
    bus.i_b_term = 1'b1;
    tick();
    bus.i_a_term = 1'b0;
    bus.i_b_term = 1'b0;
  endtask

  task automatic out_term_pulse();
    bus.i_out_term = 1'b1;
    tick();
    bus.i_out_term = 1'b0;
  endtask

  // Scoreboard: every completion pulse must match the next queued beat count.
  always @(negedge clk) begin
    if (rst_n && bus.o_run_done) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_done", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("sb_run_beats", 32'(bus.o_run_beats), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.i_pair_req  = '0;
    bus.i_a_term    = 1'b0;
    bus.i_b_term    = 1'b0;
    bus.i_out_write = 1'b0;
    bus.i_out_term  = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    check_zero("idle_no_req");

    // Round-robin with req 0110: 1, 2, 1
    bus.i_pair_req = 4'b0110;
    tick();
    check_grant("grant_p1", 1);
    bus.i_out_write = 1'b1;
    repeat (2) tick();
    bus.i_out_write = 1'b0;
    both_terms();
    chk("same_cycle_route", 32'(bus.o_route_en), 32'd0);
    chk("same_cycle_gv", 32'(bus.o_grant_valid), 32'd1);
    chk("same_cycle_err", 32'(bus.o_error), 32'd0);
    exp_q.push_back(16'd3);
    bus.i_out_write = 1'b1;  // write coincident with terminator is counted
    out_term_pulse();
    bus.i_out_write = 1'b0;
    chk("run1_done", 32'(bus.o_run_done), 32'd1);
    chk("run1_beats", 32'(bus.o_run_beats), 32'd3);
    chk("run1_done_gv", 32'(bus.o_grant_valid), 32'd0);
    chk("run1_done_oh", 32'(bus.o_grant_onehot), 32'd0);
    tick();
    chk("run1_idle_gv", 32'(bus.o_grant_valid), 32'd0);
    chk("run1_idle_done", 32'(bus.o_run_done), 32'd0);
    tick();
    check_grant("grant_p2", 2);
    both_terms();
    exp_q.push_back(16'd0);
    out_term_pulse();
    chk("run2_beats", 32'(bus.o_run_beats), 32'd0);
    repeat (2) tick();
    check_grant("grant_p1_again", 1);

    // Request change during a run is ignored
    bus.i_pair_req = 4'b0001;
    tick();
    check_grant("req_change_hold", 1);
    both_terms();
    exp_q.push_back(16'd0);
    out_term_pulse();
    repeat (2) tick();
    check_grant("grant_p0", 0);

    // a_term at t, b_term at t+5: route drops at t+6; 10 beats
    bus.i_a_term = 1'b1;
    tick();
    bus.i_a_term = 1'b0;
    chk("a_only_route", 32'(bus.o_route_en), 32'd1);
    repeat (4) tick();
    chk("t5_route", 32'(bus.o_route_en), 32'd1);
    bus.i_b_term = 1'b1;
    tick();
    bus.i_b_term = 1'b0;
    chk("t6_route", 32'(bus.o_route_en), 32'd0);
    chk("t6_gv", 32'(bus.o_grant_valid), 32'd1);
    bus.i_out_write = 1'b1;
    repeat (10) tick();
    bus.i_out_write = 1'b0;
    exp_q.push_back(16'd10);
    out_term_pulse();
    chk("ten_done", 32'(bus.o_run_done), 32'd1);
    chk("ten_beats", 32'(bus.o_run_beats), 32'd10);
    chk("ten_done_gv", 32'(bus.o_grant_valid), 32'd0);
    tick();
    chk("ten_after_done", 32'(bus.o_run_done), 32'd0);
    chk("ten_beats_held", 32'(bus.o_run_beats), 32'd10);
    tick();
    check_grant("grant_p0_b", 0);

    // DRAIN timeout after 64 cycles
    bus.i_out_write = 1'b1;
    repeat (2) tick();
    bus.i_out_write = 1'b0;
    both_terms();
    exp_q.push_back(16'd2);
    repeat (63) tick();
    chk("drain64_err", 32'(bus.o_error), 32'd0);
    chk("drain64_gv", 32'(bus.o_grant_valid), 32'd1);
    chk("drain64_done", 32'(bus.o_run_done), 32'd0);
    tick();
    chk("timeout_err", 32'(bus.o_error), 32'd1);
    chk("timeout_done", 32'(bus.o_run_done), 32'd1);
    chk("timeout_beats", 32'(bus.o_run_beats), 32'd2);
    tick();
    chk("timeout_idle_gv", 32'(bus.o_grant_valid), 32'd0);
    tick();
    check_grant("regrant_after_timeout", 0);
    chk("timeout_err_sticky", 32'(bus.o_error), 32'd1);

    // Reset mid-RUN clears sticky error
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_run");
    tick();
    rst_n = 1'b1;
    tick();
    check_grant("grant_after_reset", 0);

    // Output terminator during RUN: error, grant unchanged
    bus.i_out_term = 1'b1;
    tick();
    bus.i_out_term = 1'b0;
    chk("run_outterm_err", 32'(bus.o_error), 32'd1);
    check_grant("run_outterm_hold", 0);
    both_terms();
    chk("drain_route", 32'(bus.o_route_en), 32'd0);

    // Reset mid-DRAIN aborts run, then lowest requester wins
    bus.i_pair_req = 4'b0110;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_drain");
    repeat (2) tick();
    chk("reset_hold_done", 32'(bus.o_run_done), 32'd0);
    rst_n = 1'b1;
    tick();
    check_grant("first_after_reset", 1);

    // Beat counter saturation
    bus.i_out_write = 1'b1;
    repeat (70000) tick();
    bus.i_out_write = 1'b0;
    both_terms();
    exp_q.push_back(16'hFFFF);
    out_term_pulse();
    chk("sat_done", 32'(bus.o_run_done), 32'd1);
    chk("sat_beats", 32'(bus.o_run_beats), 32'h0000FFFF);
    tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
